// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv_seq
//  Description : EX-stage datapath ALU. Single-cycle arithmetic, logic,
//                compare and shift operations, plus an iterative unsigned
//                multiply/divide unit (one bit per cycle) with HI/LO result
//                registers. Every output is registered.
//  Ports       : clk, rst (async, active-high)
//                start_i, op_i[3:0], a_i, b_i, shamt_i    -- operation launch
//                busy_o   -- multiply/divide in progress (pipeline stall)
//                done_o   -- 1-cycle pulse, result/flags/HI/LO updated
//                result_o, zero_o, ovf_o, hi_o, lo_o      -- results
//  Revision    : 1.0  initial release
// ============================================================================
module alu_muldiv_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [3:0]         op_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [WIDTH-1:0]   result_o,
    output logic               zero_o,
    output logic               ovf_o,
    output logic [WIDTH-1:0]   hi_o,
    output logic [WIDTH-1:0]   lo_o
);

    localparam logic [3:0] c_OP_ADD  = 4'd0;
    localparam logic [3:0] c_OP_AND  = 4'd1;
    localparam logic [3:0] c_OP_OR   = 4'd2;
    localparam logic [3:0] c_OP_NOR  = 4'd3;
    localparam logic [3:0] c_OP_SLT  = 4'd4;
    localparam logic [3:0] c_OP_SLL  = 4'd5;
    localparam logic [3:0] c_OP_SRL  = 4'd6;
    localparam logic [3:0] c_OP_SUB  = 4'd7;
    localparam logic [3:0] c_OP_SLTU = 4'd8;
    localparam logic [3:0] c_OP_SRA  = 4'd9;
    localparam logic [3:0] c_OP_XOR  = 4'd10;
    localparam logic [3:0] c_OP_MULT = 4'd11;
    localparam logic [3:0] c_OP_DIV  = 4'd12;
    localparam logic [3:0] c_OP_MFHI = 4'd13;
    localparam logic [3:0] c_OP_MFLO = 4'd14;
    localparam logic [3:0] c_OP_RSVD = 4'd15;

    localparam int                CNT_W      = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  c_CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_acc;    // MUL: partial-product high half, DIV: remainder
    logic [WIDTH-1:0]   r_lo_sh;  // MUL: multiplier/product low half, DIV: dividend/quotient
    logic [WIDTH-1:0]   r_opd;    // multiplicand or divisor, frozen for the whole op

    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_ovf;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_res;
    logic               w_ovf;
    logic               w_zero;

    always_comb begin
        w_sum  = a_i + b_i;
        w_diff = a_i - b_i;
        w_res  = '0;
        w_ovf  = 1'b0;
        case (op_i)
            c_OP_ADD: begin
                w_res = w_sum;
                w_ovf = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (w_sum[WIDTH-1] != a_i[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_res = w_diff;
                w_ovf = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (w_diff[WIDTH-1] != a_i[WIDTH-1]);
            end
            c_OP_AND:  w_res = a_i & b_i;
            c_OP_OR:   w_res = a_i | b_i;
            c_OP_NOR:  w_res = ~(a_i | b_i);
            c_OP_XOR:  w_res = a_i ^ b_i;
            c_OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            c_OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
            c_OP_SLL:  w_res = a_i << shamt_i;
            c_OP_SRL:  w_res = a_i >> shamt_i;
            c_OP_SRA:  w_res = $unsigned($signed(a_i) >>> shamt_i);
            c_OP_MFHI: w_res = r_hi;
            c_OP_MFLO: w_res = r_lo;
            default:   w_res = '0;
        endcase
        // The reserved opcode reports all flags clear, including zero.
        w_zero = (w_res == '0) && (op_i != c_OP_RSVD);
    end

    // ------------------------------------------------------------------
    // One shift-add multiply step: add the multiplicand when the current
    // multiplier LSB is set, then shift {acc, lo_sh} right by one.
    // ------------------------------------------------------------------
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH-1:0]   w_mul_hi;
    logic [WIDTH-1:0]   w_mul_lo;

    always_comb begin
        w_mul_sum = {1'b0, r_acc} + (r_lo_sh[0] ? {1'b0, r_opd} : '0);
        w_mul_hi  = w_mul_sum[WIDTH:1];
        w_mul_lo  = {w_mul_sum[0], r_lo_sh[WIDTH-1:1]};
    end

    // ------------------------------------------------------------------
    // One restoring-division step: shift the next dividend bit into the
    // remainder, subtract the divisor if it fits. A zero divisor always
    // "fits", which yields an all-ones quotient and remainder == dividend.
    // ------------------------------------------------------------------
    logic [WIDTH:0]     w_div_sh;
    logic [WIDTH:0]     w_div_sub;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_rem;
    logic [WIDTH-1:0]   w_div_quo;

    always_comb begin
        w_div_sh  = {r_acc, r_lo_sh[WIDTH-1]};
        w_div_sub = w_div_sh - {1'b0, r_opd};
        w_div_ge  = (w_div_sh >= {1'b0, r_opd});
        w_div_rem = w_div_ge ? w_div_sub[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
        w_div_quo = {r_lo_sh[WIDTH-2:0], w_div_ge};
    end

    // ------------------------------------------------------------------
    // Control FSM and all registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_lo_sh  <= '0;
            r_opd    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        if ((op_i == c_OP_MULT) || (op_i == c_OP_DIV)) begin
                            r_acc   <= '0;
                            r_lo_sh <= a_i;
                            r_opd   <= b_i;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= (op_i == c_OP_MULT) ? S_MUL : S_DIV;
                        end else begin
                            r_result <= w_res;
                            r_zero   <= w_zero;
                            r_ovf    <= w_ovf;
                            r_done   <= 1'b1;
                        end
                    end
                end

                S_MUL: begin
                    r_acc   <= w_mul_hi;
                    r_lo_sh <= w_mul_lo;
                    r_cnt   <= r_cnt + 1'b1;
                    // The last iteration commits straight to the outputs so
                    // done_o follows the final step without an extra cycle.
                    if (r_cnt == c_CNT_LAST) begin
                        r_hi     <= w_mul_hi;
                        r_lo     <= w_mul_lo;
                        r_result <= w_mul_lo;
                        r_zero   <= (w_mul_lo == '0);
                        r_ovf    <= 1'b0;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end

                S_DIV: begin
                    r_acc   <= w_div_rem;
                    r_lo_sh <= w_div_quo;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        r_hi     <= w_div_rem;
                        r_lo     <= w_div_quo;
                        r_result <= w_div_quo;
                        r_zero   <= (w_div_quo == '0);
                        r_ovf    <= 1'b0;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o   = r_busy;
    assign done_o   = r_done;
    assign result_o = r_result;
    assign zero_o   = r_zero;
    assign ovf_o    = r_ovf;
    assign hi_o     = r_hi;
    assign lo_o     = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_muldiv_seq
//  Description : Directed self-checking bench for alu_muldiv_seq at WIDTH=8.
//                Expected values are hand-computed constants.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_muldiv_seq;

    localparam int WIDTH   = 8;
    localparam int SHAMT_W = 3;

    logic               clk;
    logic               rst;
    logic               start_i;
    logic [3:0]         op_i;
    logic [WIDTH-1:0]   a_i;
    logic [WIDTH-1:0]   b_i;
    logic [SHAMT_W-1:0] shamt_i;
    logic               busy_o;
    logic               done_o;
    logic [WIDTH-1:0]   result_o;
    logic               zero_o;
    logic               ovf_o;
    logic [WIDTH-1:0]   hi_o;
    logic [WIDTH-1:0]   lo_o;

    int n_tests = 0;
    int n_fail  = 0;

    alu_muldiv_seq #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .shamt_i  (shamt_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o),
        .zero_o   (zero_o),
        .ovf_o    (ovf_o),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Launch one op; returns sampled 1 time unit after the accepting edge.
    task automatic launch(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] sh);
        @(negedge clk);
        op_i    = op;
        a_i     = a;
        b_i     = b;
        shamt_i = sh;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic single(input string tag, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [2:0] sh,
                          input logic [7:0] exp_res, input logic exp_z, input logic exp_v);
        launch(op, a, b, sh);
        chk({tag, "_done"}, {31'd0, done_o}, 32'd1);
        chk({tag, "_res"},  {24'd0, result_o}, {24'd0, exp_res});
        chk({tag, "_zero"}, {31'd0, zero_o}, {31'd0, exp_z});
        chk({tag, "_ovf"},  {31'd0, ovf_o}, {31'd0, exp_v});
    endtask

    // Waits for done_o with a bound; reports edges from acceptance to done
    // and the number of done pulses seen in a short window afterwards.
    task automatic wait_done(output int cyc, output int pulses);
        cyc    = 0;
        pulses = 0;
        while (!done_o && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (done_o) pulses = 1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done_o) pulses++;
        end
    endtask

    task automatic long_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] exp_hi, input logic [7:0] exp_lo);
        int cyc, pulses;
        launch(op, a, b, 3'd0);
        chk({tag, "_busy"}, {31'd0, busy_o}, 32'd1);
        wait_done(cyc, pulses);
        chk({tag, "_lat"},    cyc, 32'd8);
        chk({tag, "_pulses"}, pulses, 32'd1);
        chk({tag, "_hi"},  {24'd0, hi_o}, {24'd0, exp_hi});
        chk({tag, "_lo"},  {24'd0, lo_o}, {24'd0, exp_lo});
        chk({tag, "_res"}, {24'd0, result_o}, {24'd0, exp_lo});
        chk({tag, "_busy_end"}, {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        int cyc, pulses;
        rst     = 1'b1;
        start_i = 1'b0;
        op_i    = 4'd0;
        a_i     = '0;
        b_i     = '0;
        shamt_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {busy_o, done_o, zero_o, ovf_o, result_o, hi_o, lo_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        //      tag      op     a      b      sh    res    z     v
        single("add",   4'd0,  8'h7F, 8'h01, 3'd0, 8'h80, 1'b0, 1'b1);
        single("sub",   4'd7,  8'h05, 8'h05, 3'd0, 8'h00, 1'b1, 1'b0);
        single("subov", 4'd7,  8'h80, 8'h01, 3'd0, 8'h7F, 1'b0, 1'b1);
        single("and",   4'd1,  8'hF0, 8'h3C, 3'd0, 8'h30, 1'b0, 1'b0);
        single("or",    4'd2,  8'hF0, 8'h0C, 3'd0, 8'hFC, 1'b0, 1'b0);
        single("nor",   4'd3,  8'h0F, 8'hF0, 3'd0, 8'h00, 1'b1, 1'b0);
        single("xor",   4'd10, 8'hAA, 8'hFF, 3'd0, 8'h55, 1'b0, 1'b0);
        single("sll",   4'd5,  8'h81, 8'hFF, 3'd1, 8'h02, 1'b0, 1'b0);
        single("sra",   4'd9,  8'h80, 8'h00, 3'd3, 8'hF0, 1'b0, 1'b0);
        single("srl",   4'd6,  8'h80, 8'h00, 3'd3, 8'h10, 1'b0, 1'b0);
        single("slt",   4'd4,  8'hFF, 8'h01, 3'd0, 8'h01, 1'b0, 1'b0);
        single("sltu",  4'd8,  8'hFF, 8'h01, 3'd0, 8'h00, 1'b1, 1'b0);
        single("rsvd",  4'd15, 8'h12, 8'h34, 3'd0, 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("done_clear", {31'd0, done_o}, 32'd0);

        // Back-to-back single-cycle starts on consecutive edges
        @(negedge clk);
        op_i = 4'd0; a_i = 8'h01; b_i = 8'h02; start_i = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b_res0", {24'd0, result_o}, 32'h03);
        op_i = 4'd2; a_i = 8'h10; b_i = 8'h01;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        chk("b2b_res1", {24'd0, result_o}, 32'h11);
        chk("b2b_done1", {31'd0, done_o}, 32'd1);

        long_op("mul", 4'd11, 8'hFF, 8'hFF, 8'hFE, 8'h01);
        single("mfhi", 4'd13, 8'h00, 8'h00, 3'd0, 8'hFE, 1'b0, 1'b0);
        single("mflo", 4'd14, 8'h00, 8'h00, 3'd0, 8'h01, 1'b0, 1'b0);
        long_op("div", 4'd12, 8'd200, 8'd7, 8'h04, 8'h1C);
        long_op("div0", 4'd12, 8'h35, 8'h00, 8'h35, 8'hFF);

        // Start during busy is ignored; operand changes in flight have no effect
        launch(4'd11, 8'h0D, 8'h0B, 3'd0);
        @(negedge clk);
        @(negedge clk);
        op_i = 4'd0; a_i = 8'hFF; b_i = 8'hFF; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        #1;
        wait_done(cyc, pulses);
        chk("ign_pulses", pulses, 32'd1);
        chk("ign_hi", {24'd0, hi_o}, 32'h00);
        chk("ign_lo", {24'd0, lo_o}, 32'h8F);
        chk("ign_res", {24'd0, result_o}, 32'h8F);

        // Reset in the middle of a divide
        launch(4'd12, 8'd200, 8'd7, 3'd0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_outs", {busy_o, done_o, zero_o, ovf_o, result_o, hi_o, lo_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done_o) pulses++;
        end
        chk("rstmid_nodone", pulses, 32'd0);
        single("post_rst", 4'd0, 8'h02, 8'h03, 3'd0, 8'h05, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
